// File: rtl/mc_datapath_p.sv
// mc_datapath_p: parametrised multicycle OTTER datapath with mem_ack stall handshake.
// Define DATAPATH_MDU_EN to build the iterative RV32M multiply/divide unit.
module mc_datapath_p #(
  parameter logic [31:0] RESET_VEC = 32'h0000_0000,
  parameter int NREGS = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enBranch,
  input  logic        pcUpdate,
  input  logic        irWrite,
  input  logic        addrSrc,
  input  logic        regWrite,
  input  logic [1:0]  regSrc,
  input  logic [2:0]  immedSrc,
  input  logic [1:0]  aluSrcA,
  input  logic [1:0]  aluSrcB,
  input  logic [3:0]  aluOp,
  input  logic        mdStart,
  input  logic        mem_ack,
  input  logic [31:0] data_in,
  output logic [31:0] addr,
  output logic [31:0] data_out,
  output logic [31:0] inst_out,
  output logic        stall,
  output logic        mdBusy,
  output logic        mdDone
);
  localparam int AW = $clog2(NREGS);
  logic [31:0] r_pc, r_old_pc, r_inst;
  logic [31:0] r_rf [NREGS];
  logic [4:0]  w_rs1a, w_rs2a, w_rd;
  logic [2:0]  w_f3;
  logic [31:0] w_rs1, w_rs2, w_imm, w_a, w_b, w_alu, w_mem, w_md, w_wd;
  logic        w_eq, w_lt, w_ltu, w_taken;

  assign w_rs1a = r_inst[19:15];
  assign w_rs2a = r_inst[24:20];
  assign w_rd   = r_inst[11:7];
  assign w_f3   = r_inst[14:12];
  // x0 and indices beyond the implemented depth read as zero
  assign w_rs1 = (w_rs1a != 5'd0 && {1'b0, w_rs1a} < 6'(NREGS)) ? r_rf[w_rs1a[AW-1:0]] : '0;
  assign w_rs2 = (w_rs2a != 5'd0 && {1'b0, w_rs2a} < 6'(NREGS)) ? r_rf[w_rs2a[AW-1:0]] : '0;

  always_ff @(posedge clk)
    if (regWrite && w_rd != 5'd0 && {1'b0, w_rd} < 6'(NREGS)) r_rf[w_rd[AW-1:0]] <= w_wd;

  assign w_imm = immedSrc == 3'd0 ? {{20{r_inst[31]}}, r_inst[31:20]} :
                 immedSrc == 3'd1 ? {{20{r_inst[31]}}, r_inst[31:25], r_inst[11:7]} :
                 immedSrc == 3'd2 ? {{20{r_inst[31]}}, r_inst[7], r_inst[30:25], r_inst[11:8], 1'b0} :
                 immedSrc == 3'd3 ? {r_inst[31:12], 12'b0} :
                 immedSrc == 3'd4 ? {{12{r_inst[31]}}, r_inst[19:12], r_inst[20], r_inst[30:21], 1'b0} : '0;

  assign w_a = aluSrcA == 2'd0 ? r_pc : aluSrcA == 2'd1 ? r_old_pc : aluSrcA == 2'd2 ? w_rs1 : '0;
  assign w_b = aluSrcB == 2'd1 ? w_imm : aluSrcB == 2'd2 ? 32'd4 : w_rs2;

  always_comb begin
    case (aluOp)
      4'b0000: w_alu = w_a + w_b;
      4'b1000: w_alu = w_a - w_b;
      4'b0001: w_alu = w_a << w_b[4:0];
      4'b0010: w_alu = {31'b0, $signed(w_a) < $signed(w_b)};
      4'b0011: w_alu = {31'b0, w_a < w_b};
      4'b0100: w_alu = w_a ^ w_b;
      4'b0101: w_alu = w_a >> w_b[4:0];
      4'b1101: w_alu = $unsigned($signed(w_a) >>> w_b[4:0]);
      4'b0110: w_alu = w_a | w_b;
      4'b0111: w_alu = w_a & w_b;
      4'b1001: w_alu = w_b;
      default: w_alu = '0;
    endcase
  end

  assign w_eq  = w_rs1 == w_rs2;
  assign w_lt  = $signed(w_rs1) < $signed(w_rs2);
  assign w_ltu = w_rs1 < w_rs2;
  assign w_taken = w_f3 == 3'b000 ? w_eq : w_f3 == 3'b001 ? ~w_eq :
                   w_f3 == 3'b100 ? w_lt : w_f3 == 3'b101 ? ~w_lt :
                   w_f3 == 3'b110 ? w_ltu : w_f3 == 3'b111 ? ~w_ltu : 1'b0;

  assign w_mem = w_f3[1:0] == 2'b00 ? {{24{~w_f3[2] & data_in[7]}}, data_in[7:0]} :
                 w_f3[1:0] == 2'b01 ? {{16{~w_f3[2] & data_in[15]}}, data_in[15:0]} : data_in;

  assign w_wd = regSrc == 2'd0 ? r_pc : regSrc == 2'd1 ? w_alu : regSrc == 2'd2 ? w_mem : w_md;

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_pc     <= RESET_VEC;
      r_old_pc <= RESET_VEC;
      r_inst   <= 32'h0000_0013;
    end else begin
      if (pcUpdate | (enBranch & w_taken)) r_pc <= w_alu;
      if (irWrite & mem_ack) begin
        r_inst   <= data_in;
        r_old_pc <= r_pc;
      end
    end

  assign addr     = addrSrc ? w_alu : r_pc;
  assign data_out = w_rs2;
  assign inst_out = r_inst;
  assign stall    = (irWrite & ~mem_ack) | mdBusy;

`ifdef DATAPATH_MDU_EN
  typedef enum logic [1:0] {IDLE, RUN, DONE} md_state_t;
  md_state_t   r_state, w_next;
  logic [4:0]  r_cnt;
  logic [63:0] r_p, w_mul_p, w_div_p, w_prod;
  logic [31:0] r_b, r_md_result, w_aabs, w_babs, w_nrem, w_dif, w_q, w_r, w_res;
  logic [32:0] w_sum, w_rem;
  logic [2:0]  r_op;
  logic        r_negq, r_negr, r_dz, r_md_done, w_sa, w_sb, w_an, w_bn, w_ge, w_load, w_step, w_fin;

  // operands iterate as magnitudes; signs are restored when the result is written
  assign w_sa   = (w_f3 == 3'b001) | (w_f3 == 3'b010) | (w_f3[2] & ~w_f3[0]);
  assign w_sb   = (w_f3 == 3'b001) | (w_f3[2] & ~w_f3[0]);
  assign w_an   = w_sa & w_rs1[31];
  assign w_bn   = w_sb & w_rs2[31];
  assign w_aabs = w_an ? -w_rs1 : w_rs1;
  assign w_babs = w_bn ? -w_rs2 : w_rs2;

  always_ff @(posedge clk or negedge rst)
    if (!rst) r_state <= IDLE;
    else r_state <= w_next;

  always_comb
    w_next = r_state == IDLE ? (mdStart ? RUN : IDLE) :
             r_state == RUN  ? (r_cnt == 5'd31 ? DONE : RUN) : IDLE;

  always_comb begin
    mdBusy = r_state != IDLE;
    w_load = r_state == IDLE && mdStart;
    w_step = r_state == RUN;
    w_fin  = r_state == DONE;
  end

  assign w_sum   = {1'b0, r_p[63:32]} + (r_p[0] ? {1'b0, r_b} : 33'd0);
  assign w_mul_p = {w_sum, r_p[31:1]};
  assign w_rem   = r_p[63:31];
  assign w_ge    = w_rem >= {1'b0, r_b};
  assign w_dif   = w_rem[31:0] - r_b;
  assign w_nrem  = w_ge ? w_dif : w_rem[31:0];
  assign w_div_p = {w_nrem, r_p[30:0], w_ge};

  assign w_prod = r_negq ? -r_p : r_p;
  assign w_q    = r_dz ? '1 : r_negq ? -r_p[31:0] : r_p[31:0];
  assign w_r    = r_negr ? -r_p[63:32] : r_p[63:32];
  assign w_res  = ~r_op[2] ? (r_op[1:0] == 2'b00 ? w_prod[31:0] : w_prod[63:32]) : (r_op[1] ? w_r : w_q);

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_p         <= '0;
      r_b         <= '0;
      r_op        <= '0;
      r_cnt       <= '0;
      r_negq      <= 1'b0;
      r_negr      <= 1'b0;
      r_dz        <= 1'b0;
      r_md_done   <= 1'b0;
      r_md_result <= '0;
    end else begin
      if (w_load) begin
        r_p    <= {32'b0, w_aabs};
        r_b    <= w_babs;
        r_op   <= w_f3;
        r_negq <= w_an ^ w_bn;
        r_negr <= w_an;
        r_dz   <= w_rs2 == 32'd0;
        r_cnt  <= '0;
      end else if (w_step) begin
        r_p   <= r_op[2] ? w_div_p : w_mul_p;
        r_cnt <= r_cnt + 5'd1;
      end
      r_md_done <= w_fin;
      if (w_fin) r_md_result <= w_res;
    end

  assign mdDone = r_md_done;
  assign w_md   = r_md_result;
`else
  logic w_unused;
  assign w_unused = mdStart;
  assign mdBusy   = 1'b0;
  assign mdDone   = 1'b0;
  assign w_md     = w_alu;
`endif
endmodule
